odyssey_spot_video: RTL and testbench
=====================================

# odyssey_spot_video

Parametrised video timing and spot renderer for the Odyssey core. It generates sync, blanking and data-enable from a pixel clock-enable. It draws up to NUM_SPOTS rectangular player/ball spots from 8-bit positions, and outputs an 8-bit luma stream that the emu wrapper copies onto VGA_R/G/B. Compared with the fixed single-mode video path it replaces, it adds configurable geometry, per-spot luma, an enable per spot, and frame-coherent position latching.

## Interface
Parameters:
- H_ACTIVE, 256, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 24, hsync width (pixels)
- H_BP, 24, horizontal back porch; H_TOTAL = sum = 320
- V_ACTIVE, 240, visible lines
- V_FP, 4, vertical front porch (lines)
- V_SYNC, 3, vsync width (lines)
- V_BP, 15, vertical back porch; V_TOTAL = sum = 262
- NUM_SPOTS, 4, spot channels (1..8)
- SPOT_W, 8, spot width in pixels
- SPOT_H, 8, spot height in lines

Ports (one clock `clk`; reset `reset_n` is asynchronous, active-low):
- clk  in  1  system clock (clk_sys, 20 MHz)
- reset_n  in  1  async active-low reset
- ce_pix  in  1  pixel enable; one pixel per clk with ce_pix=1
- pos_x  in  8*NUM_SPOTS  spot i X at [8i+7:8i], left edge
- pos_y  in  8*NUM_SPOTS  spot i Y at [8i+7:8i], top line
- spot_en  in  NUM_SPOTS  spot i enable
- spot_luma  in  8*NUM_SPOTS  spot i luma
- bg_luma  in  8  background luma inside active area
- hsync  out  1  active-high horizontal sync
- vsync  out  1  active-high vertical sync
- de  out  1  data enable (active area)
- video  out  8  luma
- frame_start  out  1  high for the one clk carrying pixel (0,0)
- hcount  out  9  registered pixel X of current output
- vcount  out  9  registered line Y of current output

## Operation
- Internal counters h (0..H_TOTAL-1) and v (0..V_TOTAL-1) change only on clk edges with ce_pix=1.
  - h wraps to 0 after H_TOTAL-1.
  - v increments on each h wrap and wraps to 0 after V_TOTAL-1.
- Decode, from pre-advance (h,v):
  - de_n = (h < H_ACTIVE) && (v < V_ACTIVE)
  - hs_n = H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC
  - vs_n = V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, for whole lines
- Spot hit i requires all three conditions:
  - shadow_en[i] = 1
  - (h − shadow_x[i]) in [0,SPOT_W), compared with 10-bit unsigned arithmetic and no wrap
  - (v − shadow_y[i]) in [0,SPOT_H), compared the same way
- Spots that extend past the active edge are clipped. They never reappear at column or line 0.
- Priority: the lowest-indexed hitting spot supplies luma.
- video_n = de_n ? (any hit ? luma of winning spot : bg_luma) : 8'h00.
- Shadow latch:
  - Trigger: the ce_pix edge where (h,v) = (0,V_ACTIVE), i.e. the first pixel of vblank.
  - Action: pos_x, pos_y, spot_en and spot_luma are copied into shadow registers.
  - Effect: changes to the inputs mid-frame show no visible tearing.
- bg_luma is not latched; it is sampled live.

## Timing
- Registered outputs: hsync, vsync, de, video, frame_start, hcount and vcount load together on each ce_pix edge.
- What they show: the decode of the (h,v) held before that edge, so all outputs are mutually aligned.
- Latency: 1 clk from the ce edge. Outputs hold between ce pulses.
- frame_start: high for exactly one clk, on the edge that loads pixel (0,0); it deasserts on the next clk edge regardless of ce_pix.
- Reset (reset_n=0) takes effect immediately, without waiting for a clock edge:
  - h, v, hcount, vcount = 0
  - hsync, vsync, de, frame_start = 0; video = 0
  - all shadow registers = 0, so every spot is disabled
- After release, the first ce edge outputs pixel (0,0) with frame_start=1.
  - No spot is visible until the first vblank latch.
- Reset asserted mid-frame: outputs go to reset values asynchronously; the frame restarts at (0,0).
- ce_pix held low: counters and outputs freeze, except that frame_start clears after one clk.
- With ce_pix every 4 clk at 20 MHz: line = 1280 clk (15.625 kHz), frame = 335360 clk (≈59.6 Hz).

## Test plan
- Reset mid-line, then release with ce every 4 clk:
  - during reset: all outputs 0 immediately, without waiting for a clock edge;
  - after release: frame_start pulses once per 335360 clk;
  - hsync: high 96 clk of every 1280 clk, rising 1088 clk after the line's first ce;
  - vsync: high for 3 lines starting at line 244.
- After one vblank with spot0 en, x=10, y=20, luma 8'hC0, bg 8'h20:
  - video = C0 for hcount 10..17 and vcount 20..27;
  - video = 20 elsewhere in the active area;
  - video = 0 while de = 0.
- Priority: spot0 at (50,50) luma 8'hFF and spot1 at (54,54) luma 8'h80.
  - Overlap region 54..57 × 54..57 shows FF.
  - Columns 58..61 on lines 54..61 show 80.
- Mid-frame latch: change spot0 x from 10 to 100 at line 120.
  - The current frame still draws at 10.
  - The frame after the next vblank draws at 100.
- Clipping and enable:
  - spot at x=252, y=236 draws only columns 252..255 and lines 236..239, with nothing at column 0 or line 0;
  - spot_en=0 shows bg only.
- ce_pix held low for 1000 clk mid-line:
  - hcount, vcount and video hold;
  - frame_start stays 0;
  - counting resumes from the held position.

Source files
------------

// File: rtl/odyssey_spot_video.sv
// Odyssey video timing generator and rectangular spot renderer.
// All outputs are registered together on ce_pix so sync, de, luma and counts stay aligned.
module odyssey_spot_video #(
    parameter int H_ACTIVE  = 256,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 24,
    parameter int H_BP      = 24,
    parameter int V_ACTIVE  = 240,
    parameter int V_FP      = 4,
    parameter int V_SYNC    = 3,
    parameter int V_BP      = 15,
    parameter int NUM_SPOTS = 4,
    parameter int SPOT_W    = 8,
    parameter int SPOT_H    = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   ce_pix,
    input  logic [8*NUM_SPOTS-1:0] pos_x,
    input  logic [8*NUM_SPOTS-1:0] pos_y,
    input  logic [NUM_SPOTS-1:0]   spot_en,
    input  logic [8*NUM_SPOTS-1:0] spot_luma,
    input  logic [7:0]             bg_luma,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   de,
    output logic [7:0]             video,
    output logic                   frame_start,
    output logic [8:0]             hcount,
    output logic [8:0]             vcount
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [8:0] H_LAST   = 9'(H_TOTAL - 1);
    localparam logic [8:0] V_LAST   = 9'(V_TOTAL - 1);
    localparam logic [8:0] H_ACT    = 9'(H_ACTIVE);
    localparam logic [8:0] V_ACT    = 9'(V_ACTIVE);
    localparam logic [8:0] HS_BEGIN = 9'(H_ACTIVE + H_FP);
    localparam logic [8:0] HS_END   = 9'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [8:0] VS_BEGIN = 9'(V_ACTIVE + V_FP);
    localparam logic [8:0] VS_END   = 9'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] SPOT_W10 = 10'(SPOT_W);
    localparam logic [9:0] SPOT_H10 = 10'(SPOT_H);

    logic [8:0] h;
    logic [8:0] v;

    logic [8*NUM_SPOTS-1:0] shadow_x;
    logic [8*NUM_SPOTS-1:0] shadow_y;
    logic [8*NUM_SPOTS-1:0] shadow_luma;
    logic [NUM_SPOTS-1:0]   shadow_en;

    logic                 de_n;
    logic                 hs_n;
    logic                 vs_n;
    logic [NUM_SPOTS-1:0] hit;
    logic                 any_hit;
    logic [7:0]           hit_luma;
    logic [7:0]           video_n;

    assign de_n = (h < H_ACT) && (v < V_ACT);
    assign hs_n = (h >= HS_BEGIN) && (h < HS_END);
    assign vs_n = (v >= VS_BEGIN) && (v < VS_END);

    // 10-bit differences: a position left of / above the spot goes hugely positive, so no wrap-around hits.
    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_SPOTS; i++) begin
            hit[i] = shadow_en[i]
                  && (({1'b0, h} - {2'b00, shadow_x[8*i +: 8]}) < SPOT_W10)
                  && (({1'b0, v} - {2'b00, shadow_y[8*i +: 8]}) < SPOT_H10);
        end
    end

    always_comb begin
        any_hit  = 1'b0;
        hit_luma = 8'h00;
        for (int i = NUM_SPOTS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                any_hit  = 1'b1;
                hit_luma = shadow_luma[8*i +: 8];
            end
        end
    end

    assign video_n = de_n ? (any_hit ? hit_luma : bg_luma) : 8'h00;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h           <= '0;
            v           <= '0;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            de          <= 1'b0;
            video       <= 8'h00;
            frame_start <= 1'b0;
            hcount      <= '0;
            vcount      <= '0;
        end else begin
            frame_start <= 1'b0;
            if (ce_pix) begin
                hsync       <= hs_n;
                vsync       <= vs_n;
                de          <= de_n;
                video       <= video_n;
                hcount      <= h;
                vcount      <= v;
                frame_start <= (h == 9'd0) && (v == 9'd0);
                if (h == H_LAST) begin
                    h <= '0;
                    v <= (v == V_LAST) ? 9'd0 : v + 9'd1;
                end else begin
                    h <= h + 9'd1;
                end
            end
        end
    end

    // Spot inputs are captured once per frame, on the first vblank pixel, so mid-frame writes cannot tear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_x    <= '0;
            shadow_y    <= '0;
            shadow_luma <= '0;
            shadow_en   <= '0;
        end else if (ce_pix && (h == 9'd0) && (v == V_ACT)) begin
            shadow_x    <= pos_x;
            shadow_y    <= pos_y;
            shadow_luma <= spot_luma;
            shadow_en   <= spot_en;
        end
    end

endmodule

// File: tb/tb_odyssey_spot_video.sv
// Directed bench for odyssey_spot_video on a reduced 52x38 raster (40x30 active) to keep frames short.
// Probe vectors are {spot config, raster position, expected luma/de}; corner cases are hand sequences.
module tb_odyssey_spot_video;

    localparam int H_ACTIVE = 40, H_FP = 4, H_SYNC = 4, H_BP = 4;
    localparam int V_ACTIVE = 30, V_FP = 2, V_SYNC = 3, V_BP = 3;
    localparam int H_TOTAL  = 52;
    localparam int V_TOTAL  = 38;
    localparam int FRAME    = H_TOTAL * V_TOTAL;
    localparam int CE_OFF = 0, CE_ALWAYS = 1, CE_QUARTER = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ce_pix;
    logic [31:0] pos_x, pos_y, spot_luma;
    logic [3:0]  spot_en;
    logic [7:0]  bg_luma;
    logic        hsync, vsync, de, frame_start;
    logic [7:0]  video;
    logic [8:0]  hcount, vcount;

    int ce_mode  = CE_ALWAYS;
    int ce_phase = 0;
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string      name;
        bit         new_cfg;
        logic [7:0] x0, y0, l0;
        bit         en0;
        logic [7:0] x1, y1, l1;
        bit         en1;
        logic [7:0] bg;
        logic [8:0] ph, pv;
        logic [7:0] exp_video;
        bit         exp_de;
    } vec_t;

    vec_t vecs[$];

    odyssey_spot_video #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .NUM_SPOTS(4), .SPOT_W(8), .SPOT_H(8)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ce_pix(ce_pix),
        .pos_x(pos_x), .pos_y(pos_y), .spot_en(spot_en), .spot_luma(spot_luma),
        .bg_luma(bg_luma), .hsync(hsync), .vsync(vsync), .de(de), .video(video),
        .frame_start(frame_start), .hcount(hcount), .vcount(vcount)
    );

    always #5 clk = ~clk;

    // ce_pix is updated just after each falling edge, so a mode change made on a falling edge governs the next rising edge.
    initial begin
        ce_pix = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            case (ce_mode)
                CE_ALWAYS:  ce_pix = 1'b1;
                CE_QUARTER: begin
                    ce_pix   = (ce_phase == 0);
                    ce_phase = (ce_phase + 1) % 4;
                end
                default:    ce_pix = 1'b0;
            endcase
        end
    end

    function automatic vec_t mk(string name, bit new_cfg,
                                logic [7:0] x0, logic [7:0] y0, logic [7:0] l0, bit en0,
                                logic [7:0] x1, logic [7:0] y1, logic [7:0] l1, bit en1,
                                logic [7:0] bg, logic [8:0] ph, logic [8:0] pv,
                                logic [7:0] exp_video, bit exp_de);
        vec_t r;
        r.name = name; r.new_cfg = new_cfg;
        r.x0 = x0; r.y0 = y0; r.l0 = l0; r.en0 = en0;
        r.x1 = x1; r.y1 = y1; r.l1 = l1; r.en1 = en1;
        r.bg = bg; r.ph = ph; r.pv = pv;
        r.exp_video = exp_video; r.exp_de = exp_de;
        return r;
    endfunction

    task automatic applyStimulus(input vec_t t);
        pos_x     = {16'h0000, t.x1, t.x0};
        pos_y     = {16'h0000, t.y1, t.y0};
        spot_luma = {16'h0000, t.l1, t.l0};
        spot_en   = {2'b00, t.en1, t.en0};
        bg_luma   = t.bg;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Returns on the first falling edge whose registered position equals (th,tv).
    task automatic waitOutput(input logic [8:0] th, input logic [8:0] tv, input int budget, input string name);
        bit found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (hcount == th && vcount == tv) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL %s: position (%0d,%0d) not reached in %0d clk", name, th, tv, budget);
        end
    endtask

    initial begin
        vec_t cfg;
        int   vs_cnt, fs_cnt, fs_last, hs_cnt, hs_rise, changes, vs_h, vs_v;
        bit   found;

        // Spot 0 at (10,20) C0, background 20.
        vecs.push_back(mk("a_left_of_spot",  1, 10,20,8'hC0,1, 0,0,8'h00,0, 8'h20,  9, 20, 8'h20, 1));
        vecs.push_back(mk("a_spot_origin",   0, 10,20,8'hC0,1, 0,0,8'h00,0, 8'h20, 10, 20, 8'hC0, 1));
        vecs.push_back(mk("a_right_of_spot", 0, 10,20,8'hC0,1, 0,0,8'h00,0, 8'h20, 18, 20, 8'h20, 1));
        vecs.push_back(mk("a_hblank",        0, 10,20,8'hC0,1, 0,0,8'h00,0, 8'h20, 45, 20, 8'h00, 0));
        vecs.push_back(mk("a_spot_corner",   0, 10,20,8'hC0,1, 0,0,8'h00,0, 8'h20, 17, 27, 8'hC0, 1));
        vecs.push_back(mk("a_below_spot",    0, 10,20,8'hC0,1, 0,0,8'h00,0, 8'h20, 10, 28, 8'h20, 1));
        // Spot 0 at (5,5) FF overlapping spot 1 at (9,9) 80.
        vecs.push_back(mk("b_overlap_tl",    1, 5,5,8'hFF,1, 9,9,8'h80,1, 8'h20,  9,  9, 8'hFF, 1));
        vecs.push_back(mk("b_spot1_only",    0, 5,5,8'hFF,1, 9,9,8'h80,1, 8'h20, 13, 10, 8'h80, 1));
        vecs.push_back(mk("b_overlap_br",    0, 5,5,8'hFF,1, 9,9,8'h80,1, 8'h20, 12, 12, 8'hFF, 1));
        vecs.push_back(mk("b_outside_both",  0, 5,5,8'hFF,1, 9,9,8'h80,1, 8'h20,  8, 13, 8'h20, 1));
        vecs.push_back(mk("b_spot1_corner",  0, 5,5,8'hFF,1, 9,9,8'h80,1, 8'h20, 16, 16, 8'h80, 1));
        // Spots straddling the right and bottom edges of the active area.
        vecs.push_back(mk("c_origin_bg",     1, 36,26,8'hC0,1, 2,28,8'h80,1, 8'h20,  0,  0, 8'h20, 1));
        vecs.push_back(mk("c_no_line_wrap",  0, 36,26,8'hC0,1, 2,28,8'h80,1, 8'h20,  4,  1, 8'h20, 1));
        vecs.push_back(mk("c_spot0_origin",  0, 36,26,8'hC0,1, 2,28,8'h80,1, 8'h20, 36, 26, 8'hC0, 1));
        vecs.push_back(mk("c_no_col_wrap",   0, 36,26,8'hC0,1, 2,28,8'h80,1, 8'h20,  2, 27, 8'h20, 1));
        vecs.push_back(mk("c_spot1_clipped", 0, 36,26,8'hC0,1, 2,28,8'h80,1, 8'h20,  4, 29, 8'h80, 1));
        vecs.push_back(mk("c_last_pixel",    0, 36,26,8'hC0,1, 2,28,8'h80,1, 8'h20, 39, 29, 8'hC0, 1));
        vecs.push_back(mk("c_past_edge",     0, 36,26,8'hC0,1, 2,28,8'h80,1, 8'h20, 40, 29, 8'h00, 0));
        // Disabled spots, then a live background change without a new latch.
        vecs.push_back(mk("d_disabled",      1, 10,20,8'hC0,0, 0,0,8'h00,0, 8'h20, 12, 22, 8'h20, 1));
        vecs.push_back(mk("d_bg_live",       0, 10,20,8'hC0,0, 0,0,8'h00,0, 8'h33, 13, 23, 8'h33, 1));

        reset_n = 1'b1;
        cfg = mk("boot", 1, 0,0,8'hC0,1, 0,0,8'h00,0, 8'h20, 0, 0, 8'h00, 0);
        applyStimulus(cfg);
        #2 reset_n = 1'b0;
        #1 checkOutput("reset_outputs", {hcount, vcount, video, de, hsync, vsync, frame_start}, 32'h0);

        // First pixel after release: frame_start set and spot still invisible because shadows were cleared.
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("first_frame_start", frame_start, 1);
        checkOutput("first_position", {hcount, vcount}, 0);
        checkOutput("first_video_bg", video, 8'h20);
        checkOutput("first_de", de, 1);
        @(negedge clk);
        checkOutput("first_fs_clear", frame_start, 0);
        checkOutput("second_hcount", hcount, 1);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            if (vecs[i].new_cfg)
                waitOutput(0, 9'(V_ACTIVE), 2 * FRAME, {vecs[i].name, "_latch"});
            waitOutput(vecs[i].ph, vecs[i].pv, 2 * FRAME, vecs[i].name);
            checkOutput({vecs[i].name, "_video"}, video, vecs[i].exp_video);
            checkOutput({vecs[i].name, "_de"}, de, vecs[i].exp_de);
        end

        // Moving spot 0 mid-frame must not affect the frame already being drawn.
        cfg = mk("latch", 1, 10,20,8'hC0,1, 0,0,8'h00,0, 8'h20, 0, 0, 8'h00, 0);
        applyStimulus(cfg);
        waitOutput(0, 9'(V_ACTIVE), 2 * FRAME, "latch_setup");
        waitOutput(0, 15, 2 * FRAME, "latch_midframe");
        pos_x[7:0] = 8'd20;
        waitOutput(10, 20, 2 * FRAME, "latch_old_pos");
        checkOutput("latch_old_pos_video", video, 8'hC0);
        waitOutput(20, 20, 2 * FRAME, "latch_new_pos_early");
        checkOutput("latch_new_pos_early_video", video, 8'h20);
        waitOutput(10, 20, 2 * FRAME, "latch_old_pos_next");
        checkOutput("latch_old_pos_next_video", video, 8'h20);
        waitOutput(20, 20, 2 * FRAME, "latch_new_pos_next");
        checkOutput("latch_new_pos_next_video", video, 8'hC0);

        // Stall the pixel enable for 1000 clk inside the spot.
        waitOutput(22, 22, 2 * FRAME, "hold_setup");
        ce_mode = CE_OFF;
        changes = 0;
        fs_cnt  = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (hcount != 9'd22 || vcount != 9'd22 || video != 8'hC0) changes++;
            if (frame_start) fs_cnt++;
        end
        checkOutput("hold_changes", changes, 0);
        checkOutput("hold_frame_start", fs_cnt, 0);
        ce_mode = CE_ALWAYS;
        @(negedge clk);
        checkOutput("hold_resume", {hcount, vcount}, {9'd23, 9'd22});

        // frame_start drops after one clk even when no further ce arrives.
        waitOutput(0, 0, 2 * FRAME, "fs_stall_setup");
        checkOutput("fs_stall_high", frame_start, 1);
        ce_mode = CE_OFF;
        @(negedge clk);
        checkOutput("fs_stall_clear", frame_start, 0);
        checkOutput("fs_stall_hcount", hcount, 0);
        ce_mode = CE_ALWAYS;

        // One full frame at one pixel per clk: vsync window and frame_start period.
        waitOutput(0, 0, 2 * FRAME, "frame_setup");
        vs_cnt = 0; fs_cnt = 0; fs_last = -1; vs_h = -1; vs_v = -1;
        for (int i = 1; i <= FRAME; i++) begin
            @(negedge clk);
            if (vsync) begin
                if (vs_cnt == 0) begin
                    vs_h = int'(hcount);
                    vs_v = int'(vcount);
                end
                vs_cnt++;
            end
            if (frame_start) begin
                fs_cnt++;
                fs_last = i;
            end
        end
        checkOutput("vsync_width", vs_cnt, 3 * H_TOTAL);
        checkOutput("vsync_start_line", vs_v, V_ACTIVE + V_FP);
        checkOutput("vsync_start_col", vs_h, 0);
        checkOutput("frame_fs_count", fs_cnt, 1);
        checkOutput("frame_fs_period", fs_last, FRAME);

        // Quarter-rate pixel enable: hsync placement within a line, then frame period.
        ce_mode = CE_QUARTER;
        waitOutput(0, 1, 8 * FRAME, "hsync_setup");
        hs_cnt = 0; hs_rise = -1;
        for (int i = 1; i < 4 * H_TOTAL; i++) begin
            @(negedge clk);
            if (hsync) begin
                if (hs_rise < 0) hs_rise = i;
                hs_cnt++;
            end
        end
        checkOutput("hsync_rise_clk", hs_rise, 4 * (H_ACTIVE + H_FP));
        checkOutput("hsync_width_clk", hs_cnt, 4 * H_SYNC);

        waitOutput(0, 0, 8 * FRAME, "q_frame_setup");
        fs_cnt = 0; fs_last = -1;
        for (int i = 1; i <= 4 * FRAME; i++) begin
            @(negedge clk);
            if (frame_start) begin
                fs_cnt++;
                fs_last = i;
            end
        end
        checkOutput("q_frame_fs_count", fs_cnt, 1);
        checkOutput("q_frame_fs_period", fs_last, 4 * FRAME);

        // Reset in the middle of vsync must clear outputs before any clock edge.
        waitOutput(5, 33, 8 * FRAME, "midreset_setup");
        checkOutput("midreset_vsync_before", vsync, 1);
        #2 reset_n = 1'b0;
        #1 checkOutput("midreset_outputs", {hcount, vcount, video, de, hsync, vsync, frame_start}, 32'h0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (frame_start) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("midreset_restart_fs", found, 1);
        checkOutput("midreset_restart_pos", {hcount, vcount}, 0);
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (hcount != 9'd0) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("midreset_advance", {found, hcount, vcount}, {1'b1, 9'd1, 9'd0});

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
